// File: rtl/boot_loader_pkg.sv
// Shared types for the boot loader: FSM encoding, frame constants
// and the length-fits-in-RAM helper.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    WAIT_MAGIC = 3'd0,
    WAIT_LEN   = 3'd1,
    LOAD       = 3'd2,
    CHECK      = 3'd3,
    RUN        = 3'd4,
    ERROR      = 3'd5
  } boot_state_t;

  localparam logic [31:0] DEFAULT_MAGIC = 32'h5249_5343;

  // Byte size of an N-word image against the room above LOAD_BASE,
  // evaluated at 34 bits so a huge N cannot wrap into range.
  function automatic logic len_fits(
    input logic [31:0] n,
    input logic [33:0] room
  );
    return {n, 2'b00} <= room;
  endfunction

endpackage

// File: rtl/boot_checksum.sv
// XOR accumulator over payload words.
// Clear has priority over enable.
module boot_checksum (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] data,
  output logic [31:0] value
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      value <= '0;
    end else if (enable) begin
      value <= value ^ data;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Receives a framed program image, writes it to RAM and
// releases the core once the checksum matches.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int          ADDRESS_BITS = 16,
  parameter int          LOAD_BASE    = 0,
  parameter logic [31:0] MAGIC        = DEFAULT_MAGIC
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [31:0]             in_data,
  output logic                    in_ready,
  output logic                    mem_wEn,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [31:0]             mem_write_data,
  output logic                    core_reset,
  output logic                    done,
  output logic                    error
);

  localparam logic [33:0] ROOM =
    (34'd1 << ADDRESS_BITS) - 34'(LOAD_BASE);
  localparam logic [ADDRESS_BITS-1:0] BASE =
    ADDRESS_BITS'(LOAD_BASE);
  localparam logic [ADDRESS_BITS-1:0] STEP =
    ADDRESS_BITS'(4);

  boot_state_t             state, state_n;
  logic [31:0]             cnt, cnt_n;
  logic [ADDRESS_BITS-1:0] addr, addr_n;
  logic                    xfer;
  logic                    wr;
  logic                    csum_clear;
  logic                    csum_en;
  logic [31:0]             csum;

  assign in_ready = !reset && (state inside
    {WAIT_MAGIC, WAIT_LEN, LOAD, CHECK});
  assign xfer = in_valid && in_ready;

  boot_checksum u_csum (
    .clock  (clock),
    .reset  (reset),
    .clear  (csum_clear),
    .enable (csum_en),
    .data   (in_data),
    .value  (csum)
  );

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    addr_n     = addr;
    wr         = 1'b0;
    csum_clear = 1'b0;
    csum_en    = 1'b0;
    unique case (state)
      WAIT_MAGIC: begin
        if (xfer && in_data == MAGIC) begin
          state_n = WAIT_LEN;
        end
      end
      WAIT_LEN: begin
        if (xfer) begin
          cnt_n      = in_data;
          addr_n     = BASE;
          csum_clear = 1'b1;
          unique case (1'b1)
            !len_fits(in_data, ROOM): state_n = ERROR;
            in_data == '0:            state_n = CHECK;
            default:                  state_n = LOAD;
          endcase
        end
      end
      LOAD: begin
        if (xfer) begin
          wr      = 1'b1;
          csum_en = 1'b1;
          addr_n  = addr + STEP;
          cnt_n   = cnt - 32'd1;
          if (cnt == 32'd1) begin
            state_n = CHECK;
          end
        end
      end
      CHECK: begin
        if (xfer) begin
          state_n = (in_data == csum) ? RUN : ERROR;
        end
      end
      RUN, ERROR: begin
        state_n = state;
      end
      default: begin
        state_n = WAIT_MAGIC;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= WAIT_MAGIC;
      cnt   <= '0;
      addr  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      addr  <= addr_n;
    end
  end

  // Outputs follow the next state so RUN/ERROR flags land
  // on the same edge as the checksum transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_wEn        <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      core_reset     <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      mem_wEn <= wr;
      if (wr) begin
        mem_address    <= addr;
        mem_write_data <= in_data;
      end
      core_reset <= (state_n != RUN);
      done       <= (state_n == RUN);
      error      <= (state_n == ERROR);
    end
  end

endmodule
